// File: rtl/onchip_stream_pkg.sv
// Shared types and constants for the on-chip memory stream reader.
// Optional feature macro: ONCHIP_STREAM_PACKET_EN (SOP/EOP sideband).
package onchip_stream_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 15;

  // Skid buffer depth; one slot covers the in-flight read, one covers a stalled head.
  localparam int BUF_DEPTH  = 2;
  localparam int FIFO_CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } state_e;

endpackage

// File: rtl/stream_skid_fifo2.sv
// Two-entry synchronous FIFO. Entry 0 is always the head, so dout is a flop
// output and stays stable while the consumer stalls. SOP/EOP sideband bits,
// when used, are packed into the upper bits of din/dout by the instantiator.
module stream_skid_fifo2
  import onchip_stream_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          din,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count,
  output logic [W-1:0]          dout
);

  logic [W-1:0]          e0_q, e0_d;
  logic [W-1:0]          e1_q, e1_d;
  logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == FIFO_CNT_W'(BUF_DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = e0_q;

  // Next-state for the shift-style storage; pop shifts entry 1 into the head.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == '0) e0_d = din;
        else             e1_d = din;
        cnt_d = cnt_q + FIFO_CNT_W'(1);
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - FIFO_CNT_W'(1);
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains.
        if (cnt_q == FIFO_CNT_W'(1)) begin
          e0_d = din;
        end else begin
          e0_d = e1_q;
          e1_d = din;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master draining a block of on-chip RAM words into an
// Avalon-ST source. The RAM has a fixed 1-cycle read latency, so at most one
// read is in flight and a 2-entry skid buffer absorbs downstream stalls.
// Optional feature macro: ONCHIP_STREAM_PACKET_EN adds src_startofpacket and
// src_endofpacket, carried per buffer entry.
module onchip_mem_stream_reader
  import onchip_stream_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
`ifdef ONCHIP_STREAM_PACKET_EN
  output logic              src_startofpacket,
  output logic              src_endofpacket,
`endif
  input  logic              src_ready
);

`ifdef ONCHIP_STREAM_PACKET_EN
  localparam int SB_W = 2;
`else
  localparam int SB_W = 0;
`endif
  localparam int FW = DATA_W + SB_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic                inflight_q, inflight_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                fifo_full, fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FW-1:0]       fifo_din, fifo_dout;
  logic                pop, issue_ok, issue;

`ifdef ONCHIP_STREAM_PACKET_EN
  logic first_q, first_d;
  logic sop_fl_q, sop_fl_d;
  logic eop_fl_q, eop_fl_d;
`endif

  assign src_valid = !fifo_empty;
  assign pop       = src_valid && src_ready;

  // A read may issue only if buffer + in-flight, after this cycle's pop, stays below 2.
  assign issue_ok = inflight_q ? (fifo_empty || (fifo_count == FIFO_CNT_W'(1) && pop))
                               : (!fifo_full || pop);
  assign issue    = (state_q == READ) && issue_ok;

  assign mem_chipselect = issue;
  assign mem_address    = addr_q;
  assign mem_clken      = 1'b1;
  assign busy           = busy_q;
  assign done           = done_q;
  assign src_data       = fifo_dout[DATA_W-1:0];

`ifdef ONCHIP_STREAM_PACKET_EN
  assign fifo_din          = {sop_fl_q, eop_fl_q, mem_readdata};
  assign src_startofpacket = fifo_dout[FW-1];
  assign src_endofpacket   = fifo_dout[FW-2];
`else
  assign fifo_din = mem_readdata;
`endif

  // Control next-state: block sequencing, address/count stepping, output regs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    inflight_d = issue;
`ifdef ONCHIP_STREAM_PACKET_EN
    first_d    = first_q;
    sop_fl_d   = sop_fl_q;
    eop_fl_d   = eop_fl_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d   = base_addr;
            remain_d = word_count;
            state_d  = READ;
`ifdef ONCHIP_STREAM_PACKET_EN
            first_d  = 1'b1;
`endif
          end else begin
            state_d = FIN;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - CNT_W'(1);
`ifdef ONCHIP_STREAM_PACKET_EN
          sop_fl_d = first_q;
          eop_fl_d = (remain_q == CNT_W'(1));
          first_d  = 1'b0;
`endif
          if (remain_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && fifo_empty) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // Control registers; reset aborts and drops any in-flight return.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ONCHIP_STREAM_PACKET_EN
      first_q    <= 1'b0;
      sop_fl_q   <= 1'b0;
      eop_fl_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef ONCHIP_STREAM_PACKET_EN
      first_q    <= first_d;
      sop_fl_q   <= sop_fl_d;
      eop_fl_q   <= eop_fl_d;
`endif
    end
  end

  stream_skid_fifo2 #(.W(FW)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .dout  (fifo_dout)
  );

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Directed bench for onchip_mem_stream_reader. RAM model holds RAM[i]=i with
// 1-cycle read latency. Define ONCHIP_STREAM_PACKET_EN to cover SOP/EOP.
module tb_onchip_mem_stream_reader;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy, done, mem_chipselect, mem_clken, src_valid;
  logic              src_ready = 1'b1;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_readdata = '0;
  logic [DATA_W-1:0] src_data;
`ifdef ONCHIP_STREAM_PACKET_EN
  logic              sop, eop;
  logic              sop_q[$];
  logic              eop_q[$];
`endif

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int e0 = 0;
  int first_vld = -1;
  int done_at = -1;
  int done_cnt = 0;
  int occ = 0;
  int occ_viol = 0;
  int stab_viol = 0;
  logic [31:0]       got_q[$];
  logic [ADDR_W-1:0] adr_q[$];
  logic              pv = 1'b0, pr = 1'b0;
  logic [31:0]       pd = '0;

  always #5 clk = ~clk;

  onchip_mem_stream_reader dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .mem_address       (mem_address),
    .mem_chipselect    (mem_chipselect),
    .mem_clken         (mem_clken),
    .mem_readdata      (mem_readdata),
    .src_data          (src_data),
    .src_valid         (src_valid),
`ifdef ONCHIP_STREAM_PACKET_EN
    .src_startofpacket (sop),
    .src_endofpacket   (eop),
`endif
    .src_ready         (src_ready)
  );

  // RAM model: RAM[i] = i, data one cycle after the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_chipselect) mem_readdata <= DATA_W'(mem_address);
  end

  // Monitor: logs transfers and reads, tracks occupancy and stall stability.
  always @(negedge clk) begin
    if (reset) begin
      occ = 0;
      pv  = 1'b0;
    end else begin
      if (pv && !pr && (!src_valid || src_data !== pd)) stab_viol++;
      if (src_valid && first_vld < 0) first_vld = cyc;
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (mem_chipselect) begin
        adr_q.push_back(mem_address);
        if (occ - int'(src_valid && src_ready) >= 2) occ_viol++;
      end
      if (src_valid && src_ready) begin
        got_q.push_back(src_data);
`ifdef ONCHIP_STREAM_PACKET_EN
        sop_q.push_back(sop);
        eop_q.push_back(eop);
`endif
      end
      occ = occ + int'(mem_chipselect) - int'(src_valid && src_ready);
      pv = src_valid;
      pr = src_ready;
      pd = src_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    adr_q.delete();
`ifdef ONCHIP_STREAM_PACKET_EN
    sop_q.delete();
    eop_q.delete();
`endif
    first_vld = -1;
    done_at   = -1;
    done_cnt  = 0;
  endtask

  // Runs one block; rs >= 0 pulses a second start that many cycles in.
  task automatic run_block(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n,
                           input bit toggle, input int rs);
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = n;
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      start = (i == rs);
      if (i == rs) begin
        base_addr  = 14'h0200;
        word_count = 15'd9;
      end
      if (toggle) src_ready = ~src_ready;
    end
    start = 1'b0;
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
    src_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_stream(input string tag, input logic [ADDR_W-1:0] b, input int n);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n; i++)
      chk({tag, "_data"}, (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF,
          32'((int'(b) + i) % 16384));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_cs"},    32'(mem_chipselect), 32'd0);
    chk({tag, "_addr"},  32'(mem_address), 32'd0);
    chk({tag, "_clken"}, 32'(mem_clken), 32'd1);
    chk({tag, "_valid"}, 32'(src_valid), 32'd0);
    chk({tag, "_data"},  src_data, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;

    // Basic block: 4 words from 0x10
    run_block(14'h0010, 15'd4, 1'b0, -1);
    check_stream("basic", 14'h0010, 4);
    chk("basic_first_valid", 32'(first_vld - e0), 32'd2);
    chk("basic_done_lat", 32'(done_at - e0), 32'd7);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);

    // Backpressure: ready toggles every cycle
    occ_viol = 0; stab_viol = 0;
    run_block(14'h0100, 15'd8, 1'b1, -1);
    check_stream("bp", 14'h0100, 8);
    chk("bp_reads", 32'(adr_q.size()), 32'd8);
    chk("bp_occ", 32'(occ_viol), 32'd0);
    chk("bp_stable", 32'(stab_viol), 32'd0);

    // Address wrap
    run_block(14'h3FFE, 15'd4, 1'b0, -1);
    chk("wrap_reads", 32'(adr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("wrap_addr", (i < adr_q.size()) ? 32'(adr_q[i]) : 32'hFFFF,
          32'((16382 + i) % 16384));
    check_stream("wrap", 14'h3FFE, 4);

    // Zero count
    run_block(14'h0040, 15'd0, 1'b0, -1);
    chk("zero_done_lat", 32'(done_at - e0), 32'd0);
    chk("zero_reads", 32'(adr_q.size()), 32'd0);
    chk("zero_words", 32'(got_q.size()), 32'd0);

    // Start while busy is ignored
    run_block(14'h0020, 15'd5, 1'b0, 2);
    check_stream("busy_start", 14'h0020, 5);
    repeat (12) @(posedge clk);
    #1;
    chk("busy_start_reads", 32'(adr_q.size()), 32'd5);
    chk("busy_start_done", 32'(done_cnt), 32'd1);

    // Reset mid-block with the 3rd word stalled
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 14'h0040; word_count = 15'd8; src_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && got_q.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    src_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_words", 32'(got_q.size()), 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("midrst");
    src_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_stale", 32'(got_q.size()), 32'd2);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    run_block(14'h0100, 15'd3, 1'b0, -1);
    check_stream("after_rst", 14'h0100, 3);

`ifdef ONCHIP_STREAM_PACKET_EN
    // Packet markers
    run_block(14'h0005, 15'd1, 1'b0, -1);
    chk("pkt1_count", 32'(sop_q.size()), 32'd1);
    chk("pkt1_sop", (sop_q.size() > 0) ? 32'(sop_q[0]) : 32'hF, 32'd1);
    chk("pkt1_eop", (eop_q.size() > 0) ? 32'(eop_q[0]) : 32'hF, 32'd1);
    run_block(14'h0007, 15'd3, 1'b0, -1);
    chk("pkt3_count", 32'(sop_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("pkt3_sop", (i < sop_q.size()) ? 32'(sop_q[i]) : 32'hF, 32'(i == 0));
      chk("pkt3_eop", (i < eop_q.size()) ? 32'(eop_q[i]) : 32'hF, 32'(i == 2));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
